// File: rtl/accum_seq_nbit.sv
// Burst accumulator: sums a length-prefixed burst of signed add/sub operands,
// tracks sticky signed overflow, and hands the result off with valid/ready.

// Shared n-bit adder/subtractor: a + (b ^ {n{add_n}}) + add_n, with signed overflow.
module add_sub_n #(
   parameter int unsigned n = 16
) (
   input  logic [n-1:0] a,
   input  logic [n-1:0] b,
   input  logic         add_n,
   output logic [n-1:0] sum_c,
   output logic         ovf_c
);

   localparam int unsigned W = n;

   logic [W-1:0] b_eff;

   // Two's-complement add/sub; carry-out is not needed by any user of this block.
   always_comb begin
      b_eff = b ^ {W{add_n}};
      sum_c = a + b_eff + W'(add_n);
      // Overflow when both effective operands share a sign the result does not.
      ovf_c = (a[W-1] == b_eff[W-1]) && (sum_c[W-1] != a[W-1]);
   end

endmodule

module accum_seq_nbit #(
   parameter int unsigned n  = 16,
   parameter int unsigned lw = 8
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic [lw-1:0] len,
   input  logic          in_valid,
   input  logic [n-1:0]  in_data,
   input  logic          in_sub,
   output logic          in_ready,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [n-1:0]  out_sum,
   output logic          out_ovf,
   output logic          busy
);

   localparam int unsigned DW = n;
   localparam int unsigned LW = lw;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic [DW-1:0] acc_q, acc_d;
   logic          ovf_q, ovf_d;
   logic [LW-1:0] remaining_q, remaining_d;
   logic          in_ready_q, in_ready_d;
   logic          out_valid_q, out_valid_d;
   logic          busy_q, busy_d;

   logic [DW-1:0] add_sum_c;
   logic          add_ovf_c;
   logic          beat_c;

   // Single adder/subtractor shared by every accepted beat.
   add_sub_n #(.n(DW)) u_add_sub (
      .a     (acc_q),
      .b     (in_data),
      .add_n (in_sub),
      .sum_c (add_sum_c),
      .ovf_c (add_ovf_c)
   );

   // Next-state, datapath and registered-output decode.
   always_comb begin
      state_d     = state_q;
      acc_d       = acc_q;
      ovf_d       = ovf_q;
      remaining_d = remaining_q;
      beat_c      = in_valid && in_ready_q;

      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               acc_d = '0;
               ovf_d = 1'b0;
               if (len != '0) begin
                  remaining_d = len;
                  state_d     = ST_RUN;
               end else begin
                  state_d = ST_DONE;
               end
            end
         end
         ST_RUN: begin
            if (beat_c) begin
               acc_d       = add_sum_c;
               ovf_d       = ovf_q | add_ovf_c;
               remaining_d = remaining_q - LW'(1);
               if (remaining_q == LW'(1)) begin
                  state_d = ST_DONE;
               end
            end
         end
         ST_DONE: begin
            if (out_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      in_ready_d  = (state_d == ST_RUN);
      out_valid_d = (state_d == ST_DONE);
      busy_d      = (state_d != ST_IDLE);
   end

   // State and output registers with asynchronous active-high clear.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         acc_q       <= '0;
         ovf_q       <= 1'b0;
         remaining_q <= '0;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         ovf_q       <= ovf_d;
         remaining_q <= remaining_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         busy_q      <= busy_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign busy      = busy_q;
   assign out_sum   = acc_q;
   assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_accum_seq_nbit.sv
// Scoreboard bench for accum_seq_nbit: driver pushes model results, monitor pops on handoff.
module tb_accum_seq_nbit;

   localparam int unsigned N  = 16;
   localparam int unsigned LW = 8;
   localparam longint MAXV = (longint'(1) << (N - 1)) - 1;
   localparam longint MINV = -(longint'(1) << (N - 1));

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          start = 1'b0;
   logic [LW-1:0] len = '0;
   logic          in_valid = 1'b0;
   logic [N-1:0]  in_data = '0;
   logic          in_sub = 1'b0;
   logic          in_ready;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [N-1:0]  out_sum;
   logic          out_ovf;
   logic          busy;

   typedef struct packed {
      logic [N-1:0] sum;
      logic         ovf;
   } exp_t;

   exp_t          sb[$];
   logic [N-1:0]  gd[$];
   bit            gs[$];

   int            n_checks = 0;
   int            n_fail = 0;
   longint        m_acc;
   bit            m_ovf;

   accum_seq_nbit #(.n(N), .lw(LW)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .len       (len),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_sub    (in_sub),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sum   (out_sum),
      .out_ovf   (out_ovf),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Signed interpretation of an n-bit pattern.
   function automatic longint to_s(input logic [N-1:0] v);
      return v[N-1] ? longint'(v) - (longint'(1) << N) : longint'(v);
   endfunction

   // Reference: exact integer arithmetic, overflow if true result leaves signed range.
   task automatic model_apply(input logic [N-1:0] d, input bit s);
      longint r;
      r = s ? m_acc - to_s(d) : m_acc + to_s(d);
      if (r > MAXV || r < MINV) m_ovf = 1'b1;
      m_acc = to_s(N'(r));
   endtask

   // Issue start in IDLE; returns one cycle later (posedge + 1).
   task automatic start_burst(input int l);
      m_acc = 0;
      m_ovf = 1'b0;
      start = 1'b1;
      len   = LW'(l);
      @(posedge clk);
      #1;
      start = 1'b0;
      len   = LW'($urandom);
   endtask

   // Drive operands until cnt beats are accepted; in_ready must hold high throughout RUN.
   task automatic drive_beats(input int cnt, input int gap);
      int           acc_n = 0;
      int           cyc = 0;
      int           irh = 0;
      logic         v;
      logic         ir;
      logic [N-1:0] d;
      bit           s;
      while (acc_n < cnt && cyc < 4000) begin
         v = ($urandom_range(0, 99) >= gap);
         if (gd.size() > 0) begin
            d = gd[0];
            s = gs[0];
         end else begin
            d = N'($urandom);
            s = bit'($urandom_range(0, 1));
         end
         in_valid = v;
         in_data  = d;
         in_sub   = s;
         ir = in_ready;
         if (ir) irh++;
         cyc++;
         @(posedge clk);
         if (v && ir) begin
            model_apply(d, s);
            if (gd.size() > 0) begin
               gd.delete(0);
               gs.delete(0);
            end
            acc_n++;
         end
         #1;
      end
      in_valid = 1'b0;
      if (cyc > 0) begin
         check("in_ready_run", 64'(irh), 64'(cyc));
         check("beats_accepted", 64'(acc_n), 64'(cnt));
      end
   endtask

   // Result must be visible now; hold it for `hold` cycles, then hand off with a start pulse.
   task automatic finish_burst(input int hold);
      exp_t e;
      e.sum = N'(m_acc);
      e.ovf = m_ovf;
      sb.push_back(e);
      check("out_valid_latency", 64'({out_valid, in_ready, busy}), 64'(3'b101));
      for (int i = 0; i < hold; i++) begin
         out_ready = 1'b0;
         start     = bit'($urandom_range(0, 1));
         len       = LW'($urandom_range(1, 9));
         check("done_hold", 64'({out_valid, in_ready, out_ovf, out_sum}),
               64'({1'b1, 1'b0, e.ovf, e.sum}));
         @(posedge clk);
         #1;
      end
      out_ready = 1'b1;
      start     = 1'b1;
      len       = LW'(5);
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      start     = 1'b0;
      check("handoff_idle", 64'({out_valid, in_ready, busy}), 64'(3'b000));
   endtask

   task automatic run_burst(input int l, input int gap, input int hold);
      start_burst(l);
      drive_beats(l, gap);
      finish_burst(hold);
   endtask

   task automatic load_op(input logic [N-1:0] d, input bit s);
      gd.push_back(d);
      gs.push_back(s);
   endtask

   // Monitor: compare each delivered result against the oldest expectation.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (!reset && out_valid && out_ready) begin
            if (sb.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_result: got sum %0h with empty scoreboard", out_sum);
            end else begin
               e = sb.pop_front();
               check("out_sum", 64'(out_sum), 64'(e.sum));
               check("out_ovf", 64'(out_ovf), 64'(e.ovf));
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      // Asynchronous reset with no clock edge involved.
      #1 reset = 1'b1;
      #1;
      check("reset_outputs", 64'({in_ready, out_valid, busy, out_ovf, out_sum}), 64'(0));
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;
      check("idle_after_reset", 64'({in_ready, out_valid, busy}), 64'(0));

      // Basic burst: +5, -3, +10 -> 12.
      load_op(N'(5), 1'b0);
      load_op(N'(3), 1'b1);
      load_op(N'(10), 1'b0);
      run_burst(3, 0, 0);

      // Sticky overflow despite in-range final value.
      load_op(N'('h7FFF), 1'b0);
      load_op(N'(1), 1'b0);
      load_op(N'(1), 1'b1);
      run_burst(3, 0, 1);

      // Zero-length burst.
      run_burst(0, 0, 0);

      // Result held for five cycles with start pulses.
      run_burst(2, 0, 5);

      // Reset mid-burst after two beats.
      start_burst(4);
      drive_beats(2, 40);
      #2 reset = 1'b1;
      #1;
      check("mid_burst_reset", 64'({in_ready, out_valid, busy, out_ovf, out_sum}), 64'(0));
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("idle_wait_after_abort", 64'({in_ready, out_valid, busy}), 64'(0));

      // New burst: 0 - 0x8000 overflows to 0x8000.
      load_op(N'('h8000), 1'b1);
      run_burst(1, 0, 0);

      // Maximum length burst.
      run_burst(255, 20, 1);

      // Random bursts.
      for (int b = 0; b < 12; b++) begin
         run_burst(int'($urandom_range(1, 20)), 30, int'($urandom_range(0, 3)));
      end

      repeat (2) @(posedge clk);
      check("scoreboard_empty", 64'(sb.size()), 64'(0));
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/accum_seq_nbit.md
ACCUM_SEQ_NBIT -- requirements
Module: accum_seq_nbit

Interface
REQ-001 Parameter n, default 16, SHALL set the operand and accumulator width in bits (two's complement).
REQ-002 Parameter lw, default 8, SHALL set the width of the burst-length input.
REQ-003 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  SHALL be the asynchronous, active-high reset.
REQ-005 start  input  1  SHALL request a new burst; sampled only in IDLE.
REQ-006 len  input  lw  SHALL give the number of operands in the burst; sampled with start.
REQ-007 in_valid  input  1  SHALL mark in_data/in_sub as valid.
REQ-008 in_data  input  n  SHALL carry the signed operand.
REQ-009 in_sub  input  1  SHALL select the operation: 0 = acc + in_data, 1 = acc - in_data.
REQ-010 in_ready  output  1  SHALL indicate that an operand can be accepted.
REQ-011 out_valid  output  1  SHALL mark out_sum/out_ovf as valid.
REQ-012 out_ready  input  1  SHALL indicate that the consumer takes the result.
REQ-013 out_sum  output  n  SHALL carry the accumulated result, wrapped to n bits.
REQ-014 out_ovf  output  1  SHALL carry the sticky signed-overflow flag for the burst.
REQ-015 busy  output  1  SHALL be high in every state except IDLE.

Function
REQ-016 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-017 IDLE with start=1 and len!=0: the FSM SHALL load remaining<=len, acc<=0 and ovf<=0, then go to RUN.
REQ-018 IDLE with start=1 and len=0: the FSM SHALL load acc<=0 and ovf<=0, then go directly to DONE.
REQ-019 start SHALL be ignored in RUN and DONE.
REQ-020 in_ready SHALL be 1 only in RUN; a beat SHALL be accepted when in_valid and in_ready are both 1.
REQ-021 On an accepted beat, the block SHALL set acc <= acc + (in_data XOR {n{in_sub}}) + in_sub, computed by one instance of the team's n-bit adder/subtractor (add_n = in_sub).
REQ-022 On an accepted beat, the block SHALL set ovf <= ovf | signed-overflow of that operation, using the operand-sign/result-sign rule; the carry-out SHALL be discarded.
REQ-023 On an accepted beat, remaining SHALL decrement by 1; the FSM SHALL go to DONE on the beat where remaining = 1.
REQ-024 Cycles in RUN with in_valid=0 SHALL change no state.
REQ-025 In DONE: out_valid SHALL be 1, out_sum SHALL equal acc and out_ovf SHALL equal ovf, all held stable until out_ready=1.
REQ-026 DONE with out_ready=1 SHALL go to IDLE at the next edge; out_valid SHALL be 0 in that following cycle.
REQ-027 Latency: out_valid SHALL rise on the clock edge that accepts the last beat, i.e. it is visible the cycle after acceptance.
REQ-028 out_ready SHALL be ignored outside DONE.
REQ-029 out_sum SHALL wrap modulo 2^n on overflow; saturation SHALL NOT be applied.
REQ-030 In IDLE and RUN, out_sum and out_ovf SHALL show the current acc and ovf, qualified by out_valid=0.
REQ-031 A start raised in the same cycle that DONE hands off SHALL be ignored; the FSM SHALL be in IDLE before start is honoured.
REQ-032 len = 2^lw - 1 SHALL be supported without wrap of remaining.

Reset
REQ-033 Asserting reset SHALL, immediately and regardless of clk, force state=IDLE, acc=0, ovf=0, remaining=0, in_ready=0, out_valid=0, busy=0, out_sum=0, out_ovf=0.
REQ-034 Reset asserted mid-burst (RUN or DONE) SHALL abandon the burst with no result delivered; after release the block SHALL wait in IDLE for start.

Verification
REQ-035 n=16, len=3, beats (+5 add), (+3 sub), (+10 add), in_valid held high -> in_ready high for 3 cycles, out_valid next cycle, out_sum=12, out_ovf=0.
REQ-036 Beats 0x7FFF add, 0x0001 add, 0x0001 sub (len=3) -> out_sum=0x7FFF, out_ovf=1 (sticky despite the final in-range result).
REQ-037 len=0 with start -> out_valid one cycle later, out_sum=0, out_ovf=0; no beat accepted.
REQ-038 len=2, out_ready held 0 for 5 cycles in DONE -> out_sum/out_ovf stable, in_ready=0, start pulses ignored; out_ready=1 -> IDLE next cycle.
REQ-039 len=4, in_valid toggled with gaps; reset pulsed asynchronously after 2 beats -> all outputs 0 at once, no out_valid; a new burst len=1 of 0x8000 sub -> out_sum=0x8000, out_ovf=1.
